vga_framebuffer_ctrl: RTL and testbench
=======================================

VGA_FRAMEBUFFER_CTRL -- requirements
Module: vga_framebuffer_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, 64, image width in pixels (power of 2, 8..256).
REQ-002 SHALL have parameter IMG_H, 64, image height in pixels (power of 2, 8..256).
REQ-003 SHALL have parameter BPP, 3, bits per pixel (1..3).
REQ-004 SHALL have parameter SCALE, 1, pixel replication factor (1, 2 or 4).
REQ-005 SHALL have parameters X_OFF, 0 and Y_OFF, 0, image top-left position on screen.
REQ-006 SHALL have derived localparam AW = clog2(IMG_W*IMG_H), the framebuffer address width.
REQ-007 SHALL have port clk, in, 1, 25 MHz pixel clock; the block's single clock.
REQ-008 SHALL have port reset_n, in, 1, synchronous active-low reset.
REQ-009 SHALL have port wr_valid, in, 1, pixel-write request.
REQ-010 SHALL have port wr_ready, out, 1, pixel-write accept.
REQ-011 SHALL have port wr_addr, in, AW, framebuffer address of the pixel write.
REQ-012 SHALL have port wr_data, in, BPP, pixel value to write.
REQ-013 SHALL have port clr_start, in, 1, clear-request pulse.
REQ-014 SHALL have port clr_color, in, BPP, fill value for clear.
REQ-015 SHALL have port border_color, in, BPP, colour for display area outside the image.
REQ-016 SHALL have port busy, out, 1, high while a clear is in progress.
REQ-017 SHALL have port done, out, 1, one-cycle pulse at clear completion.
REQ-018 SHALL have port pixel, out, BPP, registered colour output.
REQ-019 SHALL have ports hsync_out, out, 1 and vsync_out, out, 1, active-low sync.
REQ-020 SHALL have port frame_start, out, 1, one-cycle pulse aligned with output pixel (0,0).

Function
REQ-021 SHALL generate 640x480 timing: H total 800 (640/16/96/48), V total 525 (480/10/2/33); both counters wrap to 0.
REQ-022 SHALL treat a pixel as in-image when X_OFF<=x<X_OFF+IMG_W*SCALE and Y_OFF<=y<Y_OFF+IMG_H*SCALE.
REQ-023 SHALL compute read address = ((y-Y_OFF)>>log2 SCALE)*IMG_W + ((x-X_OFF)>>log2 SCALE).
REQ-024 SHALL output pixel = RAM data in-image, border_color in display area outside the image, and 0 in blanking.
REQ-025 SHALL have fixed 2-cycle latency from counter to pixel, with hsync_out/vsync_out/frame_start delayed identically.
REQ-026 SHALL use an FSM with states IDLE, CLEAR and DONE.
REQ-027 SHALL drive wr_ready = (state==IDLE) && !clr_start.
REQ-028 SHALL write wr_data to wr_addr in the cycle wr_valid && wr_ready.
REQ-029 SHALL accept but discard a write whose wr_addr >= IMG_W*IMG_H.
REQ-030 SHALL, on clr_start in IDLE, latch clr_color, enter CLEAR and write addresses 0..IMG_W*IMG_H-1, one per cycle.
REQ-031 SHALL, after the last clear write, spend one cycle in DONE with done=1, then return to IDLE.
REQ-032 SHALL ignore clr_start outside IDLE.
REQ-033 SHALL give clr_start priority over a simultaneous wr_valid in IDLE; the write is not accepted.
REQ-034 SHALL hold busy = 1 in CLEAR and DONE, and busy = 0 otherwise.
REQ-035 SHALL return old data on a same-cycle read/write to the same address.

Reset
REQ-036 SHALL, while reset_n=0 at a clk edge, clear the counters and pipeline, set state IDLE, pixel=0, hsync_out=vsync_out=1, done=busy=frame_start=0.
REQ-037 SHALL abort a clear on reset mid-operation, leaving partially cleared RAM and no done pulse.
REQ-038 SHALL leave framebuffer RAM contents unaffected by reset.

Structure
REQ-039 SHALL place the timing constants and the FSM state encoding in shared package vga_pkg.
REQ-040 SHALL instantiate sub-module vga_timing, which holds the counters and raw sync/display-enable signals.
REQ-041 SHALL infer the framebuffer as simple dual-port RAM with registered read.

Verification
REQ-042 SHALL verify: after reset, count 800 clk per hsync_out low period start and 420000 clk between frame_start pulses.
REQ-043 SHALL verify: write wr_addr=0, wr_data=3'b111 -> pixel=3'b111 at screen (0,0) 2 cycles after counter (0,0); border_color=3'b010 appears at x=64.
REQ-044 SHALL verify: clr_start with clr_color=3'b101 -> busy high for 4097 cycles, done high exactly at cycle 4097, entire image 3'b101.
REQ-045 SHALL verify: clr_start and wr_valid in the same cycle -> wr_ready=0, write lost, clear completes.
REQ-046 SHALL verify: SCALE=2, X_OFF=100 -> pixel at image address 1 shown at x=102..103 of rows Y_OFF..Y_OFF+1.
REQ-047 SHALL verify: reset_n=0 mid-clear at address 1000 -> state IDLE, no done pulse, addresses >=1000 retain old data.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480 timing constants and clear-FSM state encoding shared by the VGA blocks.
package vga_pkg;
   localparam logic [9:0] H_ACT = 10'd640;
   localparam logic [9:0] H_SS  = 10'd656;
   localparam logic [9:0] H_SE  = 10'd752;
   localparam logic [9:0] H_MAX = 10'd799;
   localparam logic [9:0] V_ACT = 10'd480;
   localparam logic [9:0] V_SS  = 10'd490;
   localparam logic [9:0] V_SE  = 10'd492;
   localparam logic [9:0] V_MAX = 10'd524;
   typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running 800x525 scan counters with raw active-low syncs,
// display enable and a frame-origin flag.
module vga_timing
   import vga_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       hs,
   output logic       vs,
   output logic       de,
   output logic       fs
);
   always_ff @(posedge clk)
      if (!reset_n) begin
         x <= '0;
         y <= '0;
      end else if (x == H_MAX) begin
         x <= '0;
         y <= (y == V_MAX) ? '0 : y + 10'd1;
      end else
         x <= x + 10'd1;
   assign hs = !(x >= H_SS && x < H_SE);
   assign vs = !(y >= V_SS && y < V_SE);
   assign de = x < H_ACT && y < V_ACT;
   assign fs = x == '0 && y == '0;
endmodule

// File: rtl/vga_framebuffer_ctrl.sv
// vga_framebuffer_ctrl: framebuffer with pixel-write/clear port and a two-stage
// scan-out pipeline placing a (optionally replicated) image inside a VGA frame.
module vga_framebuffer_ctrl
   import vga_pkg::*;
#(
   parameter  int IMG_W = 64,
   parameter  int IMG_H = 64,
   parameter  int BPP   = 3,
   parameter  int SCALE = 1,
   parameter  int X_OFF = 0,
   parameter  int Y_OFF = 0,
   localparam int AW    = $clog2(IMG_W * IMG_H)
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           wr_valid,
   output logic           wr_ready,
   input  logic [AW-1:0]  wr_addr,
   input  logic [BPP-1:0] wr_data,
   input  logic           clr_start,
   input  logic [BPP-1:0] clr_color,
   input  logic [BPP-1:0] border_color,
   output logic           busy,
   output logic           done,
   output logic [BPP-1:0] pixel,
   output logic           hsync_out,
   output logic           vsync_out,
   output logic           frame_start
);
   localparam int NPIX = IMG_W * IMG_H;
   localparam int WB   = $clog2(IMG_W);
   localparam int SH   = $clog2(SCALE);
   localparam logic [AW-1:0] LAST = AW'(NPIX - 1);
   localparam logic [AW:0]   NP   = (AW + 1)'(NPIX);
   localparam logic [15:0]   XW   = 16'(IMG_W * SCALE);
   localparam logic [15:0]   YH   = 16'(IMG_H * SCALE);

   logic [9:0] x, y;
   logic hs, vs, de, fs;
   logic [15:0] dx, dy;
   logic in_img;
   logic [AW-1:0] raddr, waddr, clr_addr;
   logic [BPP-1:0] mem [NPIX];
   logic [BPP-1:0] rd_data, wdata, clr_col;
   logic we, img1, de1, hs1, vs1, fs1;
   state_t state, nxt;

   vga_timing u_timing (
      .clk(clk), .reset_n(reset_n), .x(x), .y(y), .hs(hs), .vs(vs), .de(de), .fs(fs)
   );

   // Offsets wrap to huge values left of / above the image, so one compare per axis suffices.
   assign dx     = 16'(x) - 16'(X_OFF);
   assign dy     = 16'(y) - 16'(Y_OFF);
   assign in_img = dx < XW && dy < YH && de;
   assign raddr  = AW'(((dy >> SH) << WB) | (dx >> SH));

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rd_data <= mem[raddr];
   end

   always_ff @(posedge clk)
      if (!reset_n) begin
         {img1, de1, fs1} <= '0;
         {hs1, vs1} <= 2'b11;
         pixel <= '0;
         {hsync_out, vsync_out} <= 2'b11;
         frame_start <= 1'b0;
      end else begin
         img1 <= in_img;
         de1 <= de;
         hs1 <= hs;
         vs1 <= vs;
         fs1 <= fs;
         pixel <= img1 ? rd_data : (de1 ? border_color : '0);
         hsync_out <= hs1;
         vsync_out <= vs1;
         frame_start <= fs1;
      end

   always_ff @(posedge clk)
      if (!reset_n) begin
         state <= IDLE;
         clr_addr <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && clr_start) begin
            clr_addr <= '0;
            clr_col <= clr_color;
         end else if (state == CLEAR)
            clr_addr <= clr_addr + 1'b1;
      end

   // RAM writes are gated by reset so an aborted clear stops exactly where it was.
   always_comb begin
      nxt = (state == IDLE) ? (clr_start ? CLEAR : IDLE) :
            (state == CLEAR) ? ((clr_addr == LAST) ? DONE : CLEAR) : IDLE;
      wr_ready = state == IDLE && !clr_start;
      busy = state != IDLE;
      done = state == DONE;
      we = reset_n && (state == CLEAR || (wr_valid && wr_ready && {1'b0, wr_addr} < NP));
      waddr = (state == CLEAR) ? clr_addr : wr_addr;
      wdata = (state == CLEAR) ? clr_col : wr_data;
   end
endmodule

// File: tb/tb_vga_framebuffer_ctrl.sv
// tb_vga_framebuffer_ctrl: directed bench for clear/write control and scan-out of
// a default instance plus a SCALE=2, offset instance.
module tb_vga_framebuffer_ctrl;
   logic clk = 0;
   always #20 clk = ~clk;

   logic reset_n = 0;
   logic wr_valid = 0, clr_start = 0;
   logic [11:0] wr_addr = 0;
   logic [2:0] wr_data = 0, clr_color = 0, border_color = 3'b010;
   logic wr_ready, busy, done, hsync_out, vsync_out, frame_start;
   logic [2:0] pixel;

   logic w2_valid = 0, c2_start = 0;
   logic [11:0] w2_addr = 0;
   logic [2:0] w2_data = 0, c2_color = 0;
   logic w2_ready, busy2, done2, hs2, vs2, fs2;
   logic [2:0] pix2;

   vga_framebuffer_ctrl dut (
      .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .clr_start(clr_start), .clr_color(clr_color),
      .border_color(border_color), .busy(busy), .done(done), .pixel(pixel),
      .hsync_out(hsync_out), .vsync_out(vsync_out), .frame_start(frame_start)
   );

   vga_framebuffer_ctrl #(.SCALE(2), .X_OFF(100), .Y_OFF(20)) dut2 (
      .clk(clk), .reset_n(reset_n), .wr_valid(w2_valid), .wr_ready(w2_ready),
      .wr_addr(w2_addr), .wr_data(w2_data), .clr_start(c2_start), .clr_color(c2_color),
      .border_color(border_color), .busy(busy2), .done(done2), .pixel(pix2),
      .hsync_out(hs2), .vsync_out(vs2), .frame_start(fs2)
   );

   typedef struct {
      int x;
      int y;
      logic [2:0] p1;
      logic [2:0] p2;
   } probe_t;
   probe_t tab[24];
   logic [2:0] model[4096];
   int n_cmp = 0, n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic start_clear(input logic [2:0] col, input bit with_wr, input logic [11:0] a);
      @(negedge clk);
      clr_color = col;
      clr_start = 1;
      if (with_wr) begin
         wr_valid = 1;
         wr_addr = a;
         wr_data = 3'b111;
      end
      #1 check("wr_ready_with_clr_start", wr_ready, 0);
      @(negedge clk);
      clr_start = 0;
      wr_valid = 0;
   endtask

   task automatic watch_clear(input bit inject, output int nb, output int da, output int nd);
      nb = 0; da = 0; nd = 0;
      for (int i = 1; i <= 5000; i++) begin
         if (i > 1) @(negedge clk);
         if (!busy) break;
         nb++;
         if (done) begin nd++; da = i; end
         if (inject && i == 100) begin
            clr_start = 1;
            clr_color = 3'b000;
            #1 check("wr_ready_in_clear", wr_ready, 0);
         end
         if (inject && i == 101) clr_start = 0;
      end
   endtask

   task automatic wr1(input logic [11:0] a, input logic [2:0] d);
      @(negedge clk);
      wr_valid = 1; wr_addr = a; wr_data = d;
      #1 check("wr_ready_idle", wr_ready, 1);
      @(negedge clk);
      wr_valid = 0;
   endtask

   task automatic wr2(input logic [11:0] a, input logic [2:0] d);
      @(negedge clk);
      w2_valid = 1; w2_addr = a; w2_data = d;
      @(negedge clk);
      w2_valid = 0;
   endtask

   initial begin
      int nb, da, nd, bad, ti, x, y, pbad, hsbad, vsbad, fsbad, hpbad, nfall, hlast;
      logic [2:0] ep;
      logic prev_hs;
      tab[0]  = '{0, 0, 3'b111, 3'b010};
      tab[1]  = '{1, 0, 3'b101, 3'b010};
      tab[2]  = '{5, 0, 3'b101, 3'b010};
      tab[3]  = '{63, 0, 3'b001, 3'b010};
      tab[4]  = '{64, 0, 3'b010, 3'b010};
      tab[5]  = '{640, 0, 3'b000, 3'b000};
      tab[6]  = '{10, 1, 3'b101, 3'b010};
      tab[7]  = '{39, 15, 3'b101, 3'b010};
      tab[8]  = '{40, 15, 3'b011, 3'b010};
      tab[9]  = '{99, 20, 3'b010, 3'b010};
      tab[10] = '{100, 20, 3'b010, 3'b001};
      tab[11] = '{101, 20, 3'b010, 3'b001};
      tab[12] = '{102, 20, 3'b010, 3'b110};
      tab[13] = '{103, 20, 3'b010, 3'b110};
      tab[14] = '{104, 20, 3'b010, 3'b011};
      tab[15] = '{102, 21, 3'b010, 3'b110};
      tab[16] = '{103, 21, 3'b010, 3'b110};
      tab[17] = '{100, 22, 3'b010, 3'b100};
      tab[18] = '{16, 31, 3'b011, 3'b010};
      tab[19] = '{63, 63, 3'b110, 3'b010};
      tab[20] = '{0, 64, 3'b010, 3'b010};
      tab[21] = '{639, 100, 3'b010, 3'b010};
      tab[22] = '{0, 479, 3'b010, 3'b010};
      tab[23] = '{0, 480, 3'b000, 3'b000};

      repeat (3) @(negedge clk);
      check("rst_pixel", pixel, 0);
      check("rst_hsync", hsync_out, 1);
      check("rst_vsync", vsync_out, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_frame_start", frame_start, 0);
      check("rst_wr_ready", wr_ready, 1);
      reset_n = 1;
      @(negedge clk); check("fs_cycle1", frame_start, 0);
      @(negedge clk); check("fs_cycle2", frame_start, 1);
      @(negedge clk); check("fs_cycle3", frame_start, 0);

      // Clear to 101 with a restart attempt mid-way that must be ignored.
      start_clear(3'b101, 0, 12'd0);
      watch_clear(1, nb, da, nd);
      check("clr1_busy_cycles", nb, 4097);
      check("clr1_done_at", da, 4097);
      check("clr1_done_count", nd, 1);
      check("clr1_ready_after", wr_ready, 1);

      start_clear(3'b011, 1, 12'd5);
      watch_clear(0, nb, da, nd);
      check("clr2_busy_cycles", nb, 4097);
      check("clr2_done_at", da, 4097);
      check("clr2_done_count", nd, 1);

      // Abort a clear (with a colliding write to 2000) after addresses 0..999.
      start_clear(3'b101, 1, 12'd2000);
      repeat (1000) @(negedge clk);
      check("abort_busy_before", busy, 1);
      check("abort_done_before", done, 0);
      reset_n = 0;
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (done || busy) bad++;
      end
      check("abort_no_done_busy", bad, 0);
      reset_n = 1;
      repeat (2) @(negedge clk);
      check("abort_idle_busy", busy, 0);
      check("abort_idle_done", done, 0);
      check("abort_idle_ready", wr_ready, 1);

      wr1(12'd0, 3'b111);
      wr1(12'd63, 3'b001);
      wr1(12'd4095, 3'b110);
      wr2(12'd0, 3'b001);
      wr2(12'd1, 3'b110);
      wr2(12'd2, 3'b011);
      wr2(12'd64, 3'b100);
      for (int a = 0; a < 4096; a++) model[a] = (a < 1000) ? 3'b101 : 3'b011;
      model[0] = 3'b111;
      model[63] = 3'b001;
      model[4095] = 3'b110;

      // Restart the scan so the next frame begins at a known cycle.
      @(negedge clk); reset_n = 0;
      repeat (2) @(negedge clk);
      reset_n = 1;
      @(negedge clk); check("scan_fs_cycle1", frame_start, 0);
      ti = 0; pbad = 0; hsbad = 0; vsbad = 0; fsbad = 0; hpbad = 0; nfall = 0; hlast = -1;
      prev_hs = 1;
      for (int n = 0; n <= 420000; n++) begin
         @(negedge clk);
         if (n == 420000) begin
            check("frame_period_420000", frame_start, 1);
            break;
         end
         x = n % 800;
         y = n / 800;
         ep = (y < 480 && x < 640) ? ((x < 64 && y < 64) ? model[y*64+x] : 3'b010) : 3'b000;
         if (pixel !== ep) pbad++;
         if (hsync_out !== !(x >= 656 && x < 752)) hsbad++;
         if (vsync_out !== !(y >= 490 && y < 492)) vsbad++;
         if (frame_start !== (n == 0)) fsbad++;
         if (prev_hs && !hsync_out) begin
            if (hlast >= 0 && n - hlast != 800) hpbad++;
            hlast = n;
            nfall++;
         end
         prev_hs = hsync_out;
         if (ti < 24 && n == tab[ti].y * 800 + tab[ti].x) begin
            check($sformatf("probe(%0d,%0d)", x, y), pixel, tab[ti].p1);
            check($sformatf("probe2(%0d,%0d)", x, y), pix2, tab[ti].p2);
            ti++;
         end
         // Write address 74 in the very cycle the scan reads it; old data must be shown.
         if (n == 808) begin
            wr_valid = 1; wr_addr = 12'd74; wr_data = 3'b000;
         end
         if (n == 809) wr_valid = 0;
      end
      check("probes_reached", ti, 24);
      check("scan_pixel_errors", pbad, 0);
      check("scan_hsync_errors", hsbad, 0);
      check("scan_vsync_errors", vsbad, 0);
      check("scan_frame_start_errors", fsbad, 0);
      check("hsync_period_800", hpbad, 0);
      check("hsync_falls_per_frame", nfall, 525);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
